// File: rtl/sampled_check_sequencer_if.sv
// sampled_check_sequencer_if: run control inputs and check-result outputs of the sequencer
interface sampled_check_sequencer_if #(parameter int W = 4, parameter int CW = 8);
    logic          start;
    logic [CW-1:0] limit;
    logic          inject_en;
    logic [CW-1:0] inject_at;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] first_fail;
    modport master (
        output start, limit, inject_en, inject_at,
        input  a, b, busy, done, pass, mismatch_cnt, first_fail
    );
    modport slave (
        input  start, limit, inject_en, inject_at,
        output a, b, busy, done, pass, mismatch_cnt, first_fail
    );
endinterface

// File: rtl/sampled_check_sequencer.sv
// sampled_check_sequencer: drives lockstep counters a/b, checks their pre-edge values each RUN cycle
module sampled_check_sequencer #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input logic clk,
    input logic rst,
    sampled_check_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_n;
    logic [CW-1:0] lim_q, inj_at_q, cyc, cnt, ff;
    logic          inj_en_q, pass_q, accept, last, mm;
    logic [W-1:0]  a_q, b_q, b_inc;
    logic [CW-1:0] cnt_n;
    assign accept = state != RUN && bus.start;
    assign last   = cyc == lim_q - CW'(1);
    assign mm     = a_q != b_q;
    assign cnt_n  = (mm && cnt != '1) ? cnt + CW'(1) : cnt;
    assign b_inc  = (inj_en_q && cyc == inj_at_q) ? W'(2) : W'(1);
    always_comb begin
        state_n = state;
        if (accept)
            state_n = bus.limit == '0 ? DONE : RUN;
        else if (state == RUN && last)
            state_n = DONE;
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    // the check uses a_q/b_q before this edge's increment, so an injection shows up one index later
    always_ff @(posedge clk) begin
        if (rst) begin
            lim_q    <= '0;
            inj_en_q <= 1'b0;
            inj_at_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cyc      <= '0;
            cnt      <= '0;
            ff       <= '1;
            pass_q   <= 1'b0;
        end else if (accept) begin
            lim_q    <= bus.limit;
            inj_en_q <= bus.inject_en;
            inj_at_q <= bus.inject_at;
            a_q      <= '0;
            b_q      <= '0;
            cyc      <= '0;
            cnt      <= '0;
            ff       <= '1;
            pass_q   <= bus.limit == '0;
        end else if (state == RUN) begin
            cnt <= cnt_n;
            if (mm && ff == '1)
                ff <= cyc;
            a_q <= a_q + W'(1);
            b_q <= b_q + b_inc;
            cyc <= cyc + CW'(1);
            if (last)
                pass_q <= cnt_n == '0;
        end
    end
    assign bus.a            = a_q;
    assign bus.b            = b_q;
    assign bus.busy         = state == RUN;
    assign bus.done         = state == DONE;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = cnt;
    assign bus.first_fail   = ff;
endmodule

// File: tb/tb_sampled_check_sequencer.sv
// tb_sampled_check_sequencer: directed runs of the sequencer against hand-computed results
module tb_sampled_check_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    sampled_check_sequencer_if #(.W(4), .CW(8)) bus ();
    sampled_check_sequencer #(.W(4), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_a"}, 32'(bus.a), 0);
        check({tag, "_b"}, 32'(bus.b), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_pass"}, 32'(bus.pass), 0);
        check({tag, "_cnt"}, 32'(bus.mismatch_cnt), 0);
        check({tag, "_ff"}, 32'(bus.first_fail), 32'hFF);
    endtask
    task automatic run(input string tag, input int lim, input bit ie, input int ia, input bit hold,
                       input int ea, input int eb, input int ecnt, input int eff, input bit epass);
        int  nbusy = 0;
        int  k = 0;
        bit  seen = 0;
        bit  both = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.limit = 8'(lim);
        bus.inject_en = ie;
        bus.inject_at = 8'(ia);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        bus.limit = 8'd0;
        bus.inject_at = 8'd99;
        while (!seen && k < 600) begin
            k++;
            if (bus.busy && bus.done) both = 1;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                seen = 1;
                bus.start = 1'b0;
            end else
                @(negedge clk);
        end
        check({tag, "_done"}, 32'(seen), 1);
        check({tag, "_lat"}, 32'(k), 32'(lim + 1));
        check({tag, "_nbusy"}, 32'(nbusy), 32'(lim));
        check({tag, "_overlap"}, 32'(both), 0);
        check({tag, "_pass"}, 32'(bus.pass), 32'(epass));
        check({tag, "_cnt"}, 32'(bus.mismatch_cnt), 32'(ecnt));
        check({tag, "_ff"}, 32'(bus.first_fail), 32'(eff));
        check({tag, "_a"}, 32'(bus.a), 32'(ea));
        check({tag, "_b"}, 32'(bus.b), 32'(eb));
        repeat (3) @(negedge clk);
        check({tag, "_hold_done"}, 32'(bus.done), 1);
        check({tag, "_hold_ab"}, {24'd0, bus.a, bus.b}, {24'd0, 4'(ea), 4'(eb)});
    endtask
    initial begin
        bus.start = 1'b0;
        bus.limit = 8'd0;
        bus.inject_en = 1'b0;
        bus.inject_at = 8'd0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("idle_hold");
        run("plain10", 10, 0, 0, 0, 10, 10, 0, 255, 1);
        run("inj3", 10, 1, 3, 1, 10, 11, 6, 4, 0);
        run("wrap40", 40, 0, 0, 0, 8, 8, 0, 255, 1);
        run("zero", 0, 0, 0, 0, 0, 0, 0, 255, 1);
        run("inj_last", 10, 1, 9, 0, 10, 11, 0, 255, 1);
        run("inj_m2", 10, 1, 8, 0, 10, 11, 1, 9, 0);
        run("inj_off", 10, 0, 3, 0, 10, 10, 0, 255, 1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.limit = 8'd10;
        bus.inject_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_a", 32'(bus.a), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort");
        repeat (12) @(negedge clk);
        check("abort_nodone", 32'(bus.done), 0);
        run("after_rst", 3, 0, 0, 0, 3, 3, 0, 255, 1);
        run("hold200", 200, 1, 0, 1, 8, 9, 199, 1, 0);
        run("sat255", 255, 1, 0, 0, 15, 0, 254, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
